fft_input_loader: RTL and testbench

- Serial-to-parallel front end of the 32-point FFT.
- Accepts one real signed sample per handshake and places sample n into slot bitrev5(n), so the presented frame is already in bit-reversed order for the first butterfly stage.
- Double-buffered: a fill buffer collects the next frame while the output frame register holds the current one stable for the downstream stage.
- Frame framing is checked against an end-of-frame marker.

---
 rtl/fft_pkg.sv | 29 ++
 rtl/fft_bitrev_addr.sv | 11 +
 rtl/fft_input_loader.sv | 121 ++++++++++++
 tb/tb_fft_input_loader.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared FFT definitions: frame geometry, bit-reversal and flattened-bus slot helpers.
package fft_pkg;

  localparam int N     = 32;
  localparam int LOG2N = 5;

  typedef logic [LOG2N-1:0] idx_t;

  // Classification of one input handshake as seen by the loader.
  typedef enum logic [2:0] {
    ACC_NONE,
    ACC_SAMPLE,
    ACC_FRAME_END,
    ACC_EARLY_LAST,
    ACC_MISSING_LAST
  } acc_kind_e;

  function automatic idx_t bitrev5(input idx_t v);
    idx_t r;
    for (int i = 0; i < LOG2N; i++) r[i] = v[LOG2N-1-i];
    return r;
  endfunction

  // LSB position of slot k in a flattened bus of width-bit slots.
  function automatic int slot_lsb(input int k, input int width);
    return k * width;
  endfunction

endpackage

// File: rtl/fft_bitrev_addr.sv
// Maps the sequential sample counter to its bit-reversed fill-buffer slot.
module fft_bitrev_addr
  import fft_pkg::*;
(
  input  idx_t cnt_i,
  output idx_t addr_o
);

  assign addr_o = bitrev5(cnt_i);

endmodule

// File: rtl/fft_input_loader.sv
// Serial-to-parallel FFT front end: fills a bit-reversed buffer, then hands the
// completed frame to a held output register with valid/ready handshaking.
module fft_input_loader
  import fft_pkg::*;
#(
  parameter int p_inputWidth = 8,
  parameter int p_log2N      = LOG2N
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [p_inputWidth-1:0]   i_sample,
  input  logic                      i_valid,
  input  logic                      i_last,
  output logic                      o_ready,
  output logic [N*p_inputWidth-1:0] o_frame,
  output logic                      o_frame_valid,
  input  logic                      i_frame_ready,
  output logic                      o_sync_err
);

  localparam logic [p_log2N-1:0] cnt_last = '1;

  typedef logic [N-1:0][p_inputWidth-1:0] buf_t;

  logic [p_log2N-1:0]        cnt_q, cnt_d;
  buf_t                      fill_q, fill_d;
  logic                      fill_full_q, fill_full_d;
  logic [N*p_inputWidth-1:0] frame_q, frame_d;
  logic                      frame_valid_q, frame_valid_d;
  logic                      sync_err_q, sync_err_d;

  idx_t      wr_addr;
  logic      accept;
  logic      xfer;
  acc_kind_e acc_kind;

  fft_bitrev_addr u_bitrev_addr (
    .cnt_i  (cnt_q),
    .addr_o (wr_addr)
  );

  assign o_ready       = !fill_full_q;
  assign o_frame       = frame_q;
  assign o_frame_valid = frame_valid_q;
  assign o_sync_err    = sync_err_q;

  // accept and xfer are mutually exclusive: one needs fill_full low, the other high.
  assign accept = i_valid && !fill_full_q;
  assign xfer   = fill_full_q && (!frame_valid_q || i_frame_ready);

  always_comb begin
    acc_kind = ACC_NONE;
    if (accept) begin
      if (cnt_q == cnt_last) acc_kind = i_last ? ACC_FRAME_END  : ACC_MISSING_LAST;
      else                   acc_kind = i_last ? ACC_EARLY_LAST : ACC_SAMPLE;
    end
  end

  always_comb begin
    // NOTE: every next-state value is defaulted to hold first, so no path can infer a latch.
    cnt_d         = cnt_q;
    fill_d        = fill_q;
    fill_full_d   = fill_full_q;
    frame_d       = frame_q;
    frame_valid_d = frame_valid_q;
    sync_err_d    = 1'b0;

    unique case (acc_kind)
      ACC_SAMPLE: begin
        fill_d[wr_addr] = i_sample;
        cnt_d           = cnt_q + 1'b1;
      end
      ACC_FRAME_END: begin
        fill_d[wr_addr] = i_sample;
        fill_full_d     = 1'b1;
        cnt_d           = '0;
      end
      ACC_MISSING_LAST: begin
        fill_d[wr_addr] = i_sample;
        fill_full_d     = 1'b1;
        cnt_d           = '0;
        sync_err_d      = 1'b1;
      end
      ACC_EARLY_LAST: begin
        cnt_d      = '0;
        sync_err_d = 1'b1;
      end
      default: ;
    endcase

    // A transfer that coincides with a consume simply replaces the old frame.
    if (xfer) begin
      frame_d       = fill_q;
      frame_valid_d = 1'b1;
      fill_full_d   = 1'b0;
    end else if (i_frame_ready && frame_valid_q) begin
      frame_valid_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cnt_q         <= '0;
      // NOTE: the fill buffer is flops, not RAM, so it can and does take the async reset.
      fill_q        <= '0;
      fill_full_q   <= 1'b0;
      frame_q       <= '0;
      frame_valid_q <= 1'b0;
      sync_err_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking updates keep every register sampling pre-edge values.
      cnt_q         <= cnt_d;
      fill_q        <= fill_d;
      fill_full_q   <= fill_full_d;
      frame_q       <= frame_d;
      frame_valid_q <= frame_valid_d;
      sync_err_q    <= sync_err_d;
    end
  end

endmodule

// File: tb/tb_fft_input_loader.sv
// Self-checking bench for fft_input_loader: per-cycle vector table, directed
// corner sequences, and a randomized stream scored against a frame-level model.
module tb_fft_input_loader;
  import fft_pkg::*;

  localparam int W  = 8;
  localparam int FW = N * W;
  typedef logic [FW-1:0] frame_t;

  typedef struct {
    logic         valid;
    logic [W-1:0] sample;
    logic         last;
    logic         fr;
    logic         exp_ready;
    logic         exp_fvalid;
    logic         exp_err;
  } vec_t;

  logic         CLK;
  logic         RST;
  logic [W-1:0] i_sample;
  logic         i_valid;
  logic         i_last;
  logic         o_ready;
  frame_t       o_frame;
  logic         o_frame_valid;
  logic         i_frame_ready;
  logic         o_sync_err;

  fft_input_loader #(.p_inputWidth(W), .p_log2N(LOG2N)) dut (
    .CLK           (CLK),
    .RST           (RST),
    .i_sample      (i_sample),
    .i_valid       (i_valid),
    .i_last        (i_last),
    .o_ready       (o_ready),
    .o_frame       (o_frame),
    .o_frame_valid (o_frame_valid),
    .i_frame_ready (i_frame_ready),
    .o_sync_err    (o_sync_err)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  int checks;
  int errors;

  // Behavioural model: fill array indexed by slot, arithmetic bit reversal.
  logic [W-1:0] m_fill [N];
  int           m_cnt;
  int           exp_err;
  frame_t       exp_q [$];

  logic   mon_en;
  logic   rand_ready;
  logic   hold_pending;
  frame_t hold_frame;
  int     err_seen;

  task automatic check(input string name, input frame_t act, input frame_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    check(name, frame_t'(act), frame_t'(exp));
  endtask

  function automatic int rev_idx(input int n);
    int r;
    r = 0;
    for (int i = 0; i < LOG2N; i++) r = r * 2 + ((n >> i) % 2);
    return r;
  endfunction

  function automatic frame_t model_frame();
    frame_t f;
    for (int k = 0; k < N; k++) f[slot_lsb(k, W) +: W] = m_fill[k];
    return f;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < N; k++) m_fill[k] = '0;
    m_cnt = 0;
    exp_q.delete();
  endtask

  task automatic model_accept(input logic [W-1:0] s, input logic last);
    if (m_cnt == N - 1) begin
      m_fill[rev_idx(m_cnt)] = s;
      exp_q.push_back(model_frame());
      if (!last) exp_err++;
      m_cnt = 0;
    end else if (last) begin
      exp_err++;
      m_cnt = 0;
    end else begin
      m_fill[rev_idx(m_cnt)] = s;
      m_cnt++;
    end
  endtask

  // One call per cycle: lands at negedge, optionally randomizes ready, then monitors.
  task automatic tick();
    @(negedge CLK);
    if (rand_ready) i_frame_ready = ($urandom_range(0, 3) != 0);
    #1;
    if (mon_en) begin
      if (hold_pending) begin
        check("hold_frame", o_frame, hold_frame);
        check_bit("hold_valid", o_frame_valid, 1'b1);
      end
      hold_pending = o_frame_valid && !i_frame_ready;
      hold_frame   = o_frame;
      if (o_sync_err) err_seen++;
      if (o_frame_valid && i_frame_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rand_frame: unexpected frame %0h", o_frame);
        end else begin
          check("rand_frame", o_frame, exp_q.pop_front());
        end
      end
    end
  endtask

  task automatic send_sample(input logic [W-1:0] s, input logic last);
    int waited;
    waited = 0;
    tick();
    i_valid  = 1'b1;
    i_sample = s;
    i_last   = last;
    while (!o_ready && waited < 200) begin
      tick();
      waited++;
    end
    if (!o_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: o_ready stuck at %0b, required 1", o_ready);
      i_valid = 1'b0;
      return;
    end
    @(posedge CLK);
    model_accept(s, last);
    #1;
    i_valid = 1'b0;
    i_last  = 1'b0;
  endtask

  task automatic wait_valid(input string name);
    int n;
    n = 0;
    while (!o_frame_valid && n < 100) begin
      tick();
      n++;
    end
    check_bit(name, o_frame_valid, 1'b1);
  endtask

  vec_t   tbl [34];
  frame_t fa;
  frame_t fe;
  logic   r_last;
  int     n_wait;

  initial begin
    checks = 0; errors = 0;
    mon_en = 1'b0; rand_ready = 1'b0; hold_pending = 1'b0; hold_frame = '0;
    err_seen = 0; exp_err = 0;
    RST = 1'b0; i_sample = '0; i_valid = 1'b0; i_last = 1'b0; i_frame_ready = 1'b0;
    model_reset();

    for (int c = 0; c < 34; c++) begin
      tbl[c].valid      = (c < 32);
      tbl[c].sample     = 8'(c);
      tbl[c].last       = (c == 31);
      tbl[c].fr         = 1'b1;
      tbl[c].exp_ready  = (c != 31);
      tbl[c].exp_fvalid = (c == 32);
      tbl[c].exp_err    = 1'b0;
    end

    // Reset state
    #3;
    check_bit("rst_ready", o_ready, 1'b1);
    check_bit("rst_fvalid", o_frame_valid, 1'b0);
    check_bit("rst_err", o_sync_err, 1'b0);
    check("rst_frame", o_frame, '0);
    tick();
    RST = 1'b1;
    check_bit("rst_release_ready", o_ready, 1'b1);

    // Per-cycle table: ramp frame, latency, single stall cycle, consume
    for (int c = 0; c < 34; c++) begin
      tick();
      i_valid = tbl[c].valid; i_sample = tbl[c].sample;
      i_last  = tbl[c].last;  i_frame_ready = tbl[c].fr;
      @(posedge CLK);
      if (tbl[c].valid) model_accept(tbl[c].sample, tbl[c].last);
      #1;
      check_bit($sformatf("t%0d_ready", c), o_ready, tbl[c].exp_ready);
      check_bit($sformatf("t%0d_fvalid", c), o_frame_valid, tbl[c].exp_fvalid);
      check_bit($sformatf("t%0d_err", c), o_sync_err, tbl[c].exp_err);
      if (c == 32) begin
        check("t1_frame", o_frame, exp_q.pop_front());
        check("t1_slot1", frame_t'(o_frame[slot_lsb(1, W) +: W]), frame_t'(8'd16));
        check("t1_slot2", frame_t'(o_frame[slot_lsb(2, W) +: W]), frame_t'(8'd8));
        check("t1_slot31", frame_t'(o_frame[slot_lsb(31, W) +: W]), frame_t'(8'd31));
      end
    end
    i_valid = 1'b0; i_last = 1'b0;

    // Backpressure: A held while B fills and stalls
    i_frame_ready = 1'b0;
    for (int n = 0; n < N; n++) send_sample(8'(-n), n == N - 1);
    wait_valid("bp_a_valid");
    fa = exp_q.pop_front();
    check("bp_a_frame", o_frame, fa);
    for (int n = 0; n < N; n++) send_sample(8'(100 + n), n == N - 1);
    repeat (3) tick();
    check_bit("bp_stall_ready", o_ready, 1'b0);
    check("bp_hold_a", o_frame, fa);
    check_bit("bp_hold_valid", o_frame_valid, 1'b1);
    tick();
    i_frame_ready = 1'b1;
    @(posedge CLK); #1;
    check("bp_b_frame", o_frame, exp_q.pop_front());
    check_bit("bp_b_valid", o_frame_valid, 1'b1);
    check_bit("bp_b_ready", o_ready, 1'b1);
    tick();
    i_frame_ready = 1'b0;
    tick();
    check_bit("bp_b_still_valid", o_frame_valid, 1'b1);
    i_frame_ready = 1'b1;
    @(posedge CLK); #1;
    check_bit("bp_consumed", o_frame_valid, 1'b0);

    // Early last on the 10th sample
    for (int n = 0; n < 10; n++) send_sample(8'(50 + n), n == 9);
    check_bit("early_err_pulse", o_sync_err, 1'b1);
    tick(); tick();
    check_bit("early_err_cleared", o_sync_err, 1'b0);
    check_bit("early_no_frame", o_frame_valid, 1'b0);
    check_bit("early_no_queue", exp_q.size() == 0, 1'b1);
    for (int n = 0; n < N; n++) send_sample(8'(200 + n), n == N - 1);
    wait_valid("early_next_valid");
    check("early_next_frame", o_frame, exp_q.pop_front());

    // Missing last: frame still delivered, error flagged
    for (int n = 0; n < N; n++) send_sample(8'(7 * n + 3), 1'b0);
    check_bit("miss_err_pulse", o_sync_err, 1'b1);
    wait_valid("miss_valid");
    check("miss_frame", o_frame, exp_q.pop_front());
    tick(); tick();
    check_bit("miss_consumed", o_frame_valid, 1'b0);

    // Extreme signed values, held in the output register
    i_frame_ready = 1'b0;
    for (int n = 0; n < N; n++) send_sample((n % 2 == 0) ? 8'h80 : 8'h7F, n == N - 1);
    wait_valid("ext_valid");
    fe = exp_q.pop_front();
    check("ext_frame", o_frame, fe);
    check("ext_slot0", frame_t'(o_frame[slot_lsb(0, W) +: W]), frame_t'(8'h80));
    check("ext_slot16", frame_t'(o_frame[slot_lsb(16, W) +: W]), frame_t'(8'h7F));

    // Async reset mid-frame with a valid output frame
    for (int n = 0; n < 17; n++) send_sample(8'(n + 1), 1'b0);
    check_bit("arst_pre_valid", o_frame_valid, 1'b1);
    #2 RST = 1'b0;
    #1;
    check_bit("arst_fvalid", o_frame_valid, 1'b0);
    check("arst_frame", o_frame, '0);
    check_bit("arst_ready", o_ready, 1'b1);
    tick();
    RST = 1'b1;
    model_reset();
    check_bit("arst_release_ready", o_ready, 1'b1);
    for (int n = 0; n < N; n++) send_sample(8'(30 + n), n == N - 1);
    wait_valid("arst_fresh_valid");
    check("arst_fresh_frame", o_frame, exp_q.pop_front());

    // Randomized stream against the model
    i_frame_ready = 1'b1;
    tick(); tick();
    check_bit("rand_start_idle", o_frame_valid, 1'b0);
    exp_q.delete(); exp_err = 0; err_seen = 0; hold_pending = 1'b0;
    mon_en = 1'b1; rand_ready = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) tick();
      if (m_cnt == N - 1) r_last = ($urandom_range(0, 7) != 0);
      else                r_last = ($urandom_range(0, 99) == 0);
      send_sample(8'($urandom), r_last);
    end
    rand_ready = 1'b0;
    i_frame_ready = 1'b1;
    repeat (3) tick();
    n_wait = 0;
    while ((exp_q.size() != 0 || o_frame_valid) && n_wait < 300) begin
      tick();
      n_wait++;
    end
    mon_en = 1'b0;
    check("rand_drained", frame_t'(exp_q.size()), '0);
    check("rand_sync_errs", frame_t'(err_seen), frame_t'(exp_err));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
